mem_port_arbiter: RTL

//  Shares the single-port synchronous program/data RAM between the CPU memory path
//  (fetch, load and store address/data mux) and an external DMA/loader requester.
//  - Fixed priority to the CPU, with anti-starvation for the DMA port.
//  - Routes the granted requester onto the RAM port.
//  - Returns read data to the requester that owns it, one cycle after grant.
//  - Sits between the CPU memory mux and ram01, replacing their direct connection.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_starve_cnt.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the CPU/DMA memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  localparam int ARB_AW = 12;
  localparam int ARB_DW = 16;

  // Which requester owns the RAM read data arriving this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  // Which requester wins when both ask in the same cycle.
  typedef enum logic {
    PRI_CPU = 1'b0,
    PRI_DMA = 1'b1
  } prio_t;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// DMA anti-starvation: counts denied DMA cycles and flips priority to DMA for one access.
// Latency: prio is registered; it reflects the wait count as of the previous clock edge.
// Backpressure: none; observes dma_req/dma_gnt only.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  dma_req,
  input  logic  dma_gnt,
  output prio_t prio
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;

  // Next wait count: clear on a DMA grant, else count denied DMA cycles up to the ceiling.
  always_comb begin
    wait_nxt = wait_cnt;
    if (dma_gnt) begin
      wait_nxt = '0;
    end else if (dma_req && (wait_cnt != WAIT_MAX)) begin
      wait_nxt = wait_cnt + CW'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_nxt;
    end
  end

  // Priority flips to DMA on the edge the ceiling is reached, so the DMA wins the very next
  // cycle; it drops back to CPU after exactly one DMA grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= PRI_CPU;
    end else begin
      case (prio)
        PRI_CPU: if (wait_nxt == WAIT_MAX) prio <= PRI_DMA;
        PRI_DMA: if (dma_gnt) prio <= PRI_CPU;
        default: prio <= PRI_CPU;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between CPU (fixed priority) and DMA (anti-starvation); ARB_STATS_EN adds grant/stall counters.
// Latency: grant and RAM drive combinational in the request cycle; read data one cycle after grant.
// Backpressure: a requester holds req/we/addr/wdata until its gnt; the loser simply waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = ARB_AW,
  parameter int DW       = ARB_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          ram_wren,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   cpu_gnt_cnt,
  output logic [15:0]   dma_gnt_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  prio_t         prio;
  owner_t        rd_owner;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] cpu_rd_q;
  logic [DW-1:0] dma_rd_q;

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .dma_req (dma_req),
    .dma_gnt (dma_gnt),
    .prio    (prio)
  );

  // Grant: DMA wins only when alone or when it holds priority; the two grants are exclusive.
  always_comb begin
    dma_gnt = dma_req && (!cpu_req || (prio == PRI_DMA));
    cpu_gnt = cpu_req && !dma_gnt;
  end

  // Remember the last driven address/data so an idle RAM port does not toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (cpu_gnt) begin
      addr_q <= cpu_addr;
      data_q <= cpu_wdata;
    end else if (dma_gnt) begin
      addr_q <= dma_addr;
      data_q <= dma_wdata;
    end
  end

  // RAM port mux: granted requester drives, otherwise hold with write disabled.
  always_comb begin
    ram_wren    = 1'b0;
    ram_address = addr_q;
    ram_data    = data_q;
    if (cpu_gnt) begin
      ram_wren    = cpu_we;
      ram_address = cpu_addr;
      ram_data    = cpu_wdata;
    end else if (dma_gnt) begin
      ram_wren    = dma_we;
      ram_address = dma_addr;
      ram_data    = dma_wdata;
    end
  end

  // Track who issued the read whose data ram_q carries next cycle; writes produce no owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner <= OWN_NONE;
    end else if (cpu_gnt && !cpu_we) begin
      rd_owner <= OWN_CPU;
    end else if (dma_gnt && !dma_we) begin
      rd_owner <= OWN_DMA;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  // Capture each port's returned word so its rdata stays stable while it is not the owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rd_q <= '0;
      dma_rd_q <= '0;
    end else begin
      if (rd_owner == OWN_CPU) cpu_rd_q <= ram_q;
      if (rd_owner == OWN_DMA) dma_rd_q <= ram_q;
    end
  end

  // Read return: owner sees ram_q directly, the other port its held word.
  always_comb begin
    cpu_rvalid = (rd_owner == OWN_CPU);
    dma_rvalid = (rd_owner == OWN_DMA);
    cpu_rdata  = cpu_rvalid ? ram_q : cpu_rd_q;
    dma_rdata  = dma_rvalid ? ram_q : dma_rd_q;
  end

`ifdef ARB_STATS_EN
  // Free-running wrap-around counters of grants and of cycles any requester was kept waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_gnt_cnt <= '0;
      dma_gnt_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (cpu_gnt) cpu_gnt_cnt <= cpu_gnt_cnt + 16'd1;
      if (dma_gnt) dma_gnt_cnt <= dma_gnt_cnt + 16'd1;
      if ((cpu_req && !cpu_gnt) || (dma_req && !dma_gnt)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
